// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg: state encoding, init constants, timing defaults and command helpers for the LCD sequencer
package lcd_seq_pkg;
  typedef enum logic [2:0] {PWR_WAIT, INIT_NIB, IDLE, BYTE_HI, BYTE_LO, SETTLE} state_t;
  localparam logic [3:0] INIT_NIB_3 = 4'h3;
  localparam logic [3:0] INIT_NIB_2 = 4'h2;
  localparam logic [7:0] CMD_FUNC_SET = 8'h28;
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam int unsigned T_POWERON_DEF = 750000;
  localparam int unsigned T_INIT1_DEF = 205000;
  localparam int unsigned T_INIT2_DEF = 5000;
  localparam int unsigned T_SETUP_DEF = 2;
  localparam int unsigned T_E_HIGH_DEF = 12;
  localparam int unsigned T_NIBBLE_DEF = 50;
  localparam int unsigned T_CMD_DEF = 2000;
  localparam int unsigned T_CLEAR_DEF = 82000;
  // Clear (0x01) and Home (0x02/0x03) instructions need the long settle
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && d[7:2] == 6'd0 && d[1:0] != 2'd0;
  endfunction
  // Full-byte commands issued after the init nibbles, in order
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    return i == 2'd0 ? CMD_FUNC_SET : i == 2'd1 ? CMD_ENTRY_MODE : i == 2'd2 ? CMD_DISP_ON : CMD_CLEAR;
  endfunction
endpackage

// File: rtl/lcd_seq_ctrl_if.sv
// lcd_seq_ctrl_if: byte write request handshake and status between a requester and the LCD sequencer
interface lcd_seq_ctrl_if;
  logic req_valid;
  logic req_rs;
  logic [7:0] req_data;
  logic req_ready;
  logic init_done;
  logic busy;
  modport master (output req_valid, req_rs, req_data, input req_ready, init_done, busy);
  modport slave (input req_valid, req_rs, req_data, output req_ready, init_done, busy);
endinterface

// File: rtl/lcd_nibble_wr.sv
// lcd_nibble_wr: drives one LCD nibble with setup time and a fixed-width E pulse, then pulses done
module lcd_nibble_wr
  import lcd_seq_pkg::*;
#(
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_E_HIGH = T_E_HIGH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] nib,
  input  logic       nib_rs,
  output logic       e,
  output logic       rs,
  output logic [3:0] d,
  output logic       done
);
  typedef enum logic [1:0] {N_IDLE, N_SETUP, N_HIGH} nstate_t;
  nstate_t st;
  logic [19:0] timer;
  // rs/d are latched at start and held until the next start, so they never move while e is high
  always_ff @(posedge clk)
    if (!rst_n) begin
      st <= N_IDLE;
      timer <= '0;
      e <= 1'b0;
      rs <= 1'b0;
      d <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        N_IDLE: if (start) begin
          rs <= nib_rs;
          d <= nib;
          timer <= 20'(T_SETUP - 1);
          st <= N_SETUP;
        end
        N_SETUP: if (timer == '0) begin
          e <= 1'b1;
          timer <= 20'(T_E_HIGH - 1);
          st <= N_HIGH;
        end else timer <= timer - 20'd1;
        N_HIGH: if (timer == '0) begin
          e <= 1'b0;
          done <= 1'b1;
          st <= N_IDLE;
        end else timer <= timer - 20'd1;
        default: st <= N_IDLE;
      endcase
    end
endmodule

// File: rtl/lcd_seq_ctrl.sv
// lcd_seq_ctrl: LCD power-on init and byte write sequencer; define LCD_SEQ_FIFO_EN for a 4-entry request FIFO
module lcd_seq_ctrl
  import lcd_seq_pkg::*;
#(
  parameter int unsigned T_POWERON = T_POWERON_DEF,
  parameter int unsigned T_INIT1 = T_INIT1_DEF,
  parameter int unsigned T_INIT2 = T_INIT2_DEF,
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_E_HIGH = T_E_HIGH_DEF,
  parameter int unsigned T_NIBBLE = T_NIBBLE_DEF,
  parameter int unsigned T_CMD = T_CMD_DEF,
  parameter int unsigned T_CLEAR = T_CLEAR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  lcd_seq_ctrl_if.slave    bus,
  output logic             sf_e,
  output logic             e,
  output logic             rs,
  output logic             rw,
  output logic [3:0]       lcd_d
);
  state_t state;
  logic [19:0] timer;
  logic ph;
  logic [1:0] idx;
  logic init_done_q;
  logic cur_rs;
  logic [7:0] cur_data;
  logic nib_start;
  logic [3:0] nib_val;
  logic nib_rs;
  logic nib_done;
  logic take;
  logic take_rs;
  logic [7:0] take_data;
  logic [7:0] next_cmd;
  assign sf_e = 1'b1;
  assign rw = 1'b0;
  assign bus.init_done = init_done_q;
  assign next_cmd = init_cmd(idx + 2'd1);
`ifdef LCD_SEQ_FIFO_EN
  logic [8:0] fifo_q [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] cnt;
  logic push;
  logic pop;
  assign pop = state == IDLE && cnt != 3'd0;
  assign bus.req_ready = cnt != 3'd4 || pop;
  assign push = bus.req_valid && bus.req_ready;
  assign take = pop;
  assign {take_rs, take_data} = fifo_q[rd_ptr];
  assign bus.busy = state != IDLE || cnt != 3'd0;
  // Request queue; a pop frees a slot in the same cycle so a full queue still accepts
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) fifo_q[wr_ptr] <= {bus.req_rs, bus.req_data};
      wr_ptr <= wr_ptr + 2'(push);
      rd_ptr <= rd_ptr + 2'(pop);
      cnt <= cnt + 3'(push) - 3'(pop);
    end
`else
  assign bus.req_ready = state == IDLE;
  assign take = bus.req_valid && bus.req_ready;
  assign take_rs = bus.req_rs;
  assign take_data = bus.req_data;
  assign bus.busy = state != IDLE;
`endif
  // Sequencer: ph=0 waits for the nibble writer, ph=1 runs the settle/gap timer
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= PWR_WAIT;
      timer <= '0;
      ph <= 1'b0;
      idx <= '0;
      init_done_q <= 1'b0;
      cur_rs <= 1'b0;
      cur_data <= '0;
      nib_start <= 1'b0;
      nib_val <= '0;
      nib_rs <= 1'b0;
    end else begin
      nib_start <= 1'b0;
      case (state)
        PWR_WAIT: if (!ph) begin
          timer <= 20'(T_POWERON - 1);
          ph <= 1'b1;
        end else if (timer != '0) timer <= timer - 20'd1;
        else begin
          state <= INIT_NIB;
          ph <= 1'b0;
          nib_start <= 1'b1;
          nib_val <= INIT_NIB_3;
          nib_rs <= 1'b0;
        end
        INIT_NIB: if (!ph) begin
          if (nib_done) begin
            timer <= idx == 2'd0 ? 20'(T_INIT1 - 1) : idx == 2'd1 ? 20'(T_INIT2 - 1) : 20'(T_CMD - 1);
            ph <= 1'b1;
          end
        end else if (timer != '0) timer <= timer - 20'd1;
        else if (idx == 2'd3) begin
          state <= BYTE_HI;
          idx <= '0;
          cur_rs <= 1'b0;
          cur_data <= CMD_FUNC_SET;
          ph <= 1'b0;
          nib_start <= 1'b1;
          nib_val <= CMD_FUNC_SET[7:4];
          nib_rs <= 1'b0;
        end else begin
          idx <= idx + 2'd1;
          ph <= 1'b0;
          nib_start <= 1'b1;
          nib_val <= idx == 2'd2 ? INIT_NIB_2 : INIT_NIB_3;
          nib_rs <= 1'b0;
        end
        IDLE: if (take) begin
          state <= BYTE_HI;
          cur_rs <= take_rs;
          cur_data <= take_data;
          ph <= 1'b0;
          nib_start <= 1'b1;
          nib_val <= take_data[7:4];
          nib_rs <= take_rs;
        end
        BYTE_HI: if (!ph) begin
          if (nib_done) begin
            timer <= 20'(T_NIBBLE - 1);
            ph <= 1'b1;
          end
        end else if (timer != '0) timer <= timer - 20'd1;
        else begin
          state <= BYTE_LO;
          nib_start <= 1'b1;
          nib_val <= cur_data[3:0];
          nib_rs <= cur_rs;
        end
        BYTE_LO: if (nib_done) begin
          state <= SETTLE;
          timer <= is_long_cmd(cur_rs, cur_data) ? 20'(T_CLEAR - 1) : 20'(T_CMD - 1);
        end
        SETTLE: if (timer != '0) timer <= timer - 20'd1;
        else if (!init_done_q && idx != 2'd3) begin
          state <= BYTE_HI;
          idx <= idx + 2'd1;
          cur_data <= next_cmd;
          ph <= 1'b0;
          nib_start <= 1'b1;
          nib_val <= next_cmd[7:4];
          nib_rs <= 1'b0;
        end else begin
          state <= IDLE;
          init_done_q <= 1'b1;
        end
        default: state <= PWR_WAIT;
      endcase
    end
  lcd_nibble_wr #(.T_SETUP(T_SETUP), .T_E_HIGH(T_E_HIGH)) u_nib (
    .clk(clk),
    .rst_n(rst_n),
    .start(nib_start),
    .nib(nib_val),
    .nib_rs(nib_rs),
    .e(e),
    .rs(rs),
    .d(lcd_d),
    .done(nib_done)
  );
endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// tb_lcd_seq_ctrl: directed self-checking bench for lcd_seq_ctrl with reduced timings
module tb_lcd_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sf_e, e, rs, rw;
  logic [3:0] lcd_d;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hi_cnt = 0;
  int hold_bad = 0;
  int first_rise = -1;
  logic e_p = 1'b0;
  logic rs_p = 1'b0;
  logic [3:0] d_p = '0;
  logic [4:0] nibq[$];
  int fallq[$];
  int widq[$];

  lcd_seq_ctrl_if bus ();

  lcd_seq_ctrl #(
    .T_POWERON(100), .T_INIT1(40), .T_INIT2(20), .T_SETUP(2),
    .T_E_HIGH(3), .T_NIBBLE(5), .T_CMD(10), .T_CLEAR(30)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .sf_e(sf_e), .e(e), .rs(rs), .rw(rw), .lcd_d(lcd_d)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Records every E pulse: {rs,lcd_d} at the falling edge, fall cycle and high width
  always @(negedge clk) begin
    if (e) begin
      if (e_p && (rs !== rs_p || lcd_d !== d_p)) hold_bad++;
      if (!e_p && first_rise < 0) first_rise = cyc;
      hi_cnt++;
    end else if (e_p) begin
      nibq.push_back({rs, lcd_d});
      fallq.push_back(cyc);
      widq.push_back(hi_cnt);
      hi_cnt = 0;
    end
    e_p = e;
    rs_p = rs;
    d_p = lcd_d;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    nibq.delete();
    fallq.delete();
    widq.delete();
    hold_bad = 0;
    first_rise = -1;
  endtask

  task automatic send(input logic r, input logic [7:0] dat);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 300) begin tick(); n++; end
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL send_wait_ready: req_ready=%b want 1", bus.req_ready); end
    clear_mon();
    bus.req_valid = 1'b1;
    bus.req_rs = r;
    bus.req_data = dat;
    tick();
    bus.req_valid = 1'b0;
`ifndef LCD_SEQ_FIFO_EN
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL ready_drop: req_ready=%b want 0", bus.req_ready); end
`endif
  endtask

  task automatic wait_idle(input int lim, output int c);
    int n = 0;
    while (bus.busy !== 1'b0 && n < lim) begin tick(); n++; end
    c = cyc;
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_timeout: busy=%b want 0", bus.busy); end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0;
    bus.req_rs = 1'b0;
    bus.req_data = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({e, rs, lcd_d} !== 6'b0) begin n_bad++; $display("FAIL reset_lcd: e/rs/d=%b want 000000", {e, rs, lcd_d}); end
    n_cmp++;
    if ({rw, sf_e} !== 2'b01) begin n_bad++; $display("FAIL reset_rw_sfe: %b want 01", {rw, sf_e}); end
    n_cmp++;
    if (bus.init_done !== 1'b0 || bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL reset_status: init_done=%b busy=%b want 0 1", bus.init_done, bus.busy);
    end
`ifndef LCD_SEQ_FIFO_EN
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: %b want 0", bus.req_ready); end
`endif
  endtask

  task automatic test_init();
    int n = 0;
    int dc, rel, bw, gap, st;
    int s[11] = '{40, 20, 10, 10, 5, 10, 5, 10, 5, 10, 5};
    logic [4:0] ex[12] = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};
    clear_mon();
    rst_n = 1'b1;
    rel = cyc + 1;
    while (bus.init_done !== 1'b1 && n < 3000) begin tick(); n++; end
    dc = cyc;
    n_cmp++;
    if (bus.init_done !== 1'b1) begin n_bad++; $display("FAIL init_timeout: init_done=%b want 1", bus.init_done); end
    n_cmp++;
    if (first_rise - rel < 100 || first_rise - rel > 110) begin
      n_bad++; $display("FAIL poweron_wait: first E after %0d cycles want 100..110", first_rise - rel);
    end
    n_cmp++;
    if (nibq.size() != 12) begin n_bad++; $display("FAIL init_count: %0d nibbles want 12", nibq.size()); end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (i >= nibq.size() || nibq[i] !== ex[i]) begin
        n_bad++; $display("FAIL init_nib_%0d: {rs,d}=%h want %h", i, i < nibq.size() ? nibq[i] : 5'h1f, ex[i]);
      end
    end
    bw = 0;
    foreach (widq[i]) if (widq[i] != 3) bw++;
    n_cmp++;
    if (bw != 0 || widq.size() != 12) begin n_bad++; $display("FAIL init_e_width: %0d bad widths of %0d want 0 of 12", bw, widq.size()); end
    for (int i = 0; i < 11; i++) begin
      gap = i + 1 < fallq.size() ? fallq[i + 1] - fallq[i] : -1;
      n_cmp++;
      if (gap < s[i] + 5 || gap > s[i] + 10) begin
        n_bad++; $display("FAIL init_gap_%0d: %0d cycles want %0d..%0d", i, gap, s[i] + 5, s[i] + 10);
      end
    end
    st = fallq.size() == 12 ? dc - fallq[11] : -1;
    n_cmp++;
    if (st < 30 || st > 33) begin n_bad++; $display("FAIL init_final_settle: %0d want 30..33", st); end
    n_cmp++;
    if (bus.busy !== 1'b0 || hold_bad != 0) begin
      n_bad++; $display("FAIL init_idle: busy=%b hold_bad=%0d want 0 0", bus.busy, hold_bad);
    end
  endtask

  task automatic test_data_write();
    int c, gap, st;
    send(1'b1, 8'h41);
    wait_idle(500, c);
    n_cmp++;
    if (nibq.size() != 2 || nibq[0] !== 5'h14 || nibq[1] !== 5'h11) begin
      n_bad++; $display("FAIL data_nibbles: n=%0d %h %h want 14 11", nibq.size(), nibq[0], nibq[1]);
    end
    n_cmp++;
    if (widq.size() != 2 || widq[0] != 3 || widq[1] != 3) begin
      n_bad++; $display("FAIL data_e_width: n=%0d %0d %0d want 3 3", widq.size(), widq[0], widq[1]);
    end
    gap = fallq.size() == 2 ? fallq[1] - fallq[0] : -1;
    st = fallq.size() == 2 ? c - fallq[1] : -1;
    n_cmp++;
    if (gap < 10 || gap > 15) begin n_bad++; $display("FAIL data_nibble_gap: %0d want 10..15", gap); end
    n_cmp++;
    if (st < 10 || st > 13) begin n_bad++; $display("FAIL data_settle: %0d want 10..13", st); end
    n_cmp++;
    if (hold_bad != 0 || rw !== 1'b0 || sf_e !== 1'b1) begin
      n_bad++; $display("FAIL data_hold: hold_bad=%0d rw=%b sf_e=%b want 0 0 1", hold_bad, rw, sf_e);
    end
  endtask

  task automatic test_long_cmd();
    logic [8:0] v[6] = '{9'h001, 9'h101, 9'h003, 9'h002, 9'h004, 9'h000};
    int t[6] = '{30, 10, 30, 30, 10, 10};
    int c, st;
    for (int i = 0; i < 6; i++) begin
      send(v[i][8], v[i][7:0]);
      wait_idle(500, c);
      n_cmp++;
      if (nibq.size() != 2 || nibq[0] !== {v[i][8], v[i][7:4]} || nibq[1] !== {v[i][8], v[i][3:0]}) begin
        n_bad++; $display("FAIL cmd_nibbles_%0d: n=%0d %h %h want %h %h", i, nibq.size(), nibq[0], nibq[1],
                          {v[i][8], v[i][7:4]}, {v[i][8], v[i][3:0]});
      end
      st = fallq.size() == 2 ? c - fallq[1] : -1;
      n_cmp++;
      if (st < t[i] || st > t[i] + 3) begin n_bad++; $display("FAIL cmd_settle_%0d: %0d want %0d..%0d", i, st, t[i], t[i] + 3); end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int rel, c;
    int early = 0;
    send(1'b0, 8'hC0);
    while (e !== 1'b1 && n < 50) begin tick(); n++; end
    n_cmp++;
    if (e !== 1'b1) begin n_bad++; $display("FAIL mid_e_wait: e=%b want 1", e); end
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (e !== 1'b0) begin n_bad++; $display("FAIL mid_reset_e: e=%b want 0", e); end
    n_cmp++;
    if (bus.init_done !== 1'b0 || bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL mid_reset_status: init_done=%b busy=%b want 0 1", bus.init_done, bus.busy);
    end
    tick();
`ifndef LCD_SEQ_FIFO_EN
    bus.req_valid = 1'b1;
    bus.req_rs = 1'b1;
    bus.req_data = 8'h55;
`endif
    clear_mon();
    rst_n = 1'b1;
    rel = cyc + 1;
    n = 0;
    while (bus.init_done !== 1'b1 && n < 3000) begin
      if (bus.req_ready === 1'b1) early++;
      tick();
      n++;
    end
    n_cmp++;
    if (bus.init_done !== 1'b1) begin n_bad++; $display("FAIL reinit_timeout: init_done=%b want 1", bus.init_done); end
    n_cmp++;
    if (first_rise - rel < 100 || first_rise - rel > 110) begin
      n_bad++; $display("FAIL reinit_poweron_wait: %0d want 100..110", first_rise - rel);
    end
`ifndef LCD_SEQ_FIFO_EN
    n_cmp++;
    if (early != 0 || bus.req_ready !== 1'b1) begin
      n_bad++; $display("FAIL hold_first_accept: early=%0d ready_at_init_done=%b want 0 1", early, bus.req_ready);
    end
    clear_mon();
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready_drop: %b want 0", bus.req_ready); end
    wait_idle(500, c);
    n_cmp++;
    if (nibq.size() != 2 || nibq[0] !== 5'h15 || nibq[1] !== 5'h15) begin
      n_bad++; $display("FAIL hold_nibbles: n=%0d %h %h want 15 15", nibq.size(), nibq[0], nibq[1]);
    end
`endif
  endtask

`ifdef LCD_SEQ_FIFO_EN
  task automatic test_fifo();
    logic [8:0] v[5] = '{9'h141, 9'h142, 9'h0C0, 9'h143, 9'h144};
    int at[5] = '{-1, -1, -1, -1, -1};
    logic fifth_init = 1'b0;
    int acc = 0;
    int n = 0;
    int c;
    rst_n = 1'b0;
    repeat (2) tick();
    clear_mon();
    rst_n = 1'b1;
    while (acc < 5 && n < 3000) begin
      bus.req_valid = 1'b1;
      {bus.req_rs, bus.req_data} = v[acc];
      if (bus.req_ready === 1'b1) begin
        at[acc] = n;
        if (acc == 4) fifth_init = bus.init_done;
        acc++;
      end
      tick();
      n++;
    end
    bus.req_valid = 1'b0;
    n_cmp++;
    if (at[3] != 3) begin n_bad++; $display("FAIL fifo_four_fast: 4th accept at tick %0d want 3", at[3]); end
    n_cmp++;
    if (acc != 5 || fifth_init !== 1'b1 || at[4] < 100) begin
      n_bad++; $display("FAIL fifo_fifth_stall: acc=%0d init_done=%b tick=%0d want 5 1 >=100", acc, fifth_init, at[4]);
    end
    wait_idle(3000, c);
    n_cmp++;
    if (nibq.size() != 22) begin n_bad++; $display("FAIL fifo_count: %0d nibbles want 22", nibq.size()); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (nibq.size() != 22 || nibq[12 + 2 * i] !== {v[i][8], v[i][7:4]} || nibq[13 + 2 * i] !== {v[i][8], v[i][3:0]}) begin
        n_bad++; $display("FAIL fifo_order_%0d: %h %h want %h %h", i, nibq[12 + 2 * i], nibq[13 + 2 * i],
                          {v[i][8], v[i][7:4]}, {v[i][8], v[i][3:0]});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_init();
    test_data_write();
    test_long_cmd();
    test_reset_mid();
`ifdef LCD_SEQ_FIFO_EN
    test_fifo();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
